player_bullet: RTL and testbench

Player projectile engine for the shooter. It owns a small pool of upward-travelling bullets spawned from the player sprite and drives the per-pixel `b_on`/`rgb` overlay into the VGA mux. It produces `hit_w_enemy`, which the wave-enemy blocks consume. It detects bullet-to-enemy pixel overlap using the enemies' `e_w_on`, retires the bullet that scored, and emits a one-cycle score pulse to the score counter.

---
 rtl/player_bullet.sv | 155 +++++++++++++++
 tb/tb_player_bullet.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_bullet.sv
// rtl/player_bullet.sv - player projectile pool: spawn, upward motion, pixel overlay and enemy hit scoring
// A HIT slot stays drawn and parked until the next frame start so slower enemy logic can still sample the overlap.
module player_bullet #(
    parameter int          N_BULLETS    = 4,
    parameter logic [23:0] BULLET_SPEED = 24'd200000,
    parameter int          STEP         = 2,
    parameter logic [23:0] COOLDOWN     = 24'd5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause,
    input  logic       game_start_on,
    input  logic       game_over_on,
    input  logic       fire,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       e_w_on,
    output logic       b_on,
    output logic       hit_w_enemy,
    output logic [7:0] rgb,
    output logic       score_pulse,
    output logic [3:0] active_count
);
    typedef enum logic [1:0] {FREE = 2'd0, FLY = 2'd1, HIT = 2'd2} slot_t;

    localparam logic [9:0] EXIT_Y  = 10'(31 + STEP);
    localparam logic [9:0] STEP_PX = 10'(STEP);

    slot_t                st      [N_BULLETS];
    slot_t                st_n    [N_BULLETS];
    logic [9:0]           bx      [N_BULLETS];
    logic [9:0]           bx_n    [N_BULLETS];
    logic [9:0]           by      [N_BULLETS];
    logic [9:0]           by_n    [N_BULLETS];
    logic [23:0]          cd, cd_n, mcnt, mcnt_n;
    logic                 fire_q, org_q;
    logic [N_BULLETS-1:0] cov, hit_oh, free_oh;
    logic                 hit_any, free_any, shot, flush, tick, at_org, frame_start;

    assign flush       = game_start_on | game_over_on;
    assign at_org      = (x == 10'd0) && (y == 10'd0);
    assign frame_start = at_org & ~org_q;
    assign tick        = (mcnt == 24'd0) & ~pause;

    always_comb begin
        cov = '0;
        for (int k = 0; k < N_BULLETS; k++) begin
            cov[k] = (st[k] != FREE)
                  && (x >= bx[k]) && ({1'b0, x} < ({1'b0, bx[k]} + 11'd2))
                  && (y >= by[k]) && ({1'b0, y} < ({1'b0, by[k]} + 11'd6));
        end
    end

    // Lowest index wins both for the scoring hit and for the spawn slot.
    always_comb begin
        hit_oh   = '0;
        free_oh  = '0;
        hit_any  = 1'b0;
        free_any = 1'b0;
        for (int k = 0; k < N_BULLETS; k++) begin
            if (!hit_any && cov[k] && (st[k] == FLY) && e_w_on && !pause && !flush) begin
                hit_oh[k] = 1'b1;
                hit_any   = 1'b1;
            end
            if (!free_any && (st[k] == FREE)) begin
                free_oh[k] = 1'b1;
                free_any   = 1'b1;
            end
        end
    end

    assign shot = fire & ~fire_q & (cd == 24'd0) & ~pause & ~flush & free_any;

    always_comb begin
        for (int k = 0; k < N_BULLETS; k++) begin
            st_n[k] = st[k];
            bx_n[k] = bx[k];
            by_n[k] = by[k];
            if (flush) begin
                st_n[k] = FREE;
            end else if (hit_oh[k]) begin
                st_n[k] = HIT;
            end else begin
                case (st[k])
                    FLY: begin
                        if (tick) begin
                            if (by[k] <= EXIT_Y) st_n[k] = FREE;
                            else                 by_n[k] = by[k] - STEP_PX;
                        end
                    end
                    HIT: begin
                        if (frame_start) st_n[k] = FREE;
                    end
                    FREE: begin
                        if (shot && free_oh[k]) begin
                            st_n[k] = FLY;
                            bx_n[k] = player_x + 10'd7;
                            by_n[k] = player_y - 10'd6;
                        end
                    end
                    default: st_n[k] = FREE;
                endcase
            end
        end
    end

    always_comb begin
        cd_n = cd;
        if (flush)                   cd_n = 24'd0;
        else if (shot)               cd_n = COOLDOWN;
        else if (cd != 24'd0 && !pause) cd_n = cd - 24'd1;

        mcnt_n = mcnt;
        if (!pause) mcnt_n = (mcnt >= BULLET_SPEED - 24'd1) ? 24'd0 : mcnt + 24'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_BULLETS; k++) begin
                st[k] <= FREE;
                bx[k] <= 10'd0;
                by[k] <= 10'd0;
            end
            cd          <= 24'd0;
            mcnt        <= 24'd0;
            fire_q      <= 1'b0;
            org_q       <= 1'b0;
            score_pulse <= 1'b0;
        end else begin
            for (int k = 0; k < N_BULLETS; k++) begin
                st[k] <= st_n[k];
                bx[k] <= bx_n[k];
                by[k] <= by_n[k];
            end
            cd          <= cd_n;
            mcnt        <= mcnt_n;
            fire_q      <= fire;
            org_q       <= at_org;
            score_pulse <= hit_any;
        end
    end

    always_comb begin
        active_count = 4'd0;
        for (int k = 0; k < N_BULLETS; k++) begin
            if (st[k] != FREE) active_count = active_count + 4'd1;
        end
    end

    assign b_on        = |cov;
    assign hit_w_enemy = b_on & ~pause;
    assign rgb         = b_on ? 8'b1111_1100 : 8'h00;
endmodule

// File: tb/tb_player_bullet.sv
// tb/tb_player_bullet.sv - randomized and directed self-checking bench for player_bullet
module tb_player_bullet;
    localparam int NB = 4, SPEED = 4, COOL = 10;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       pause = 0, game_start_on = 0, game_over_on = 0, fire = 0, e_w_on = 0;
    logic [9:0] player_x = 0, player_y = 0, x = 0, y = 0;
    logic       b_on, hit_w_enemy, score_pulse;
    logic [7:0] rgb;
    logic [3:0] active_count;

    int total = 0, bad = 0;

    // Reference pool: 0 = empty, 1 = flying, 2 = scored and parked
    int m_st [NB];
    int m_bx [NB];
    int m_by [NB];
    int m_cd, m_mc;
    bit m_fq, m_orgq, m_sp;

    player_bullet #(.N_BULLETS(NB), .BULLET_SPEED(24'd4), .STEP(2), .COOLDOWN(24'd10)) dut (
        .clk(clk), .rst_n(rst_n), .pause(pause), .game_start_on(game_start_on),
        .game_over_on(game_over_on), .fire(fire), .player_x(player_x), .player_y(player_y),
        .x(x), .y(y), .e_w_on(e_w_on), .b_on(b_on), .hit_w_enemy(hit_w_enemy), .rgb(rgb),
        .score_pulse(score_pulse), .active_count(active_count)
    );

    always #100 clk = ~clk;

    function automatic bit covers(int k, int px, int py);
        return m_st[k] != 0 && px >= m_bx[k] && px < m_bx[k] + 2 && py >= m_by[k] && py < m_by[k] + 6;
    endfunction

    function automatic bit m_bon();
        for (int k = 0; k < NB; k++) if (covers(k, int'(x), int'(y))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_active();
        int n = 0;
        for (int k = 0; k < NB; k++) if (m_st[k] != 0) n++;
        return n;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NB; k++) begin m_st[k] = 0; m_bx[k] = 0; m_by[k] = 0; end
        m_cd = 0; m_mc = 0; m_fq = 0; m_orgq = 0; m_sp = 0;
    endtask

    task automatic step();
        int  n_st [NB];
        int  n_bx [NB];
        int  n_by [NB];
        int  hk, fk, n_cd, n_mc;
        bit  flush, rise, tk, fs, shot, origin, n_fq;
        if (!rst_n) begin
            @(posedge clk);
            m_reset();
            #1;
        end else begin
            flush  = game_start_on || game_over_on;
            rise   = fire && !m_fq;
            tk     = (m_mc == 0) && !pause;
            origin = (x == 0) && (y == 0);
            fs     = origin && !m_orgq;
            n_fq   = fire;
            hk = -1; fk = -1;
            for (int k = 0; k < NB; k++) begin
                if (hk < 0 && !flush && !pause && e_w_on && m_st[k] == 1 && covers(k, int'(x), int'(y))) hk = k;
                if (fk < 0 && m_st[k] == 0) fk = k;
            end
            shot = rise && m_cd == 0 && !pause && !flush && fk >= 0;
            for (int k = 0; k < NB; k++) begin
                n_st[k] = m_st[k]; n_bx[k] = m_bx[k]; n_by[k] = m_by[k];
                if (flush) n_st[k] = 0;
                else if (k == hk) n_st[k] = 2;
                else if (m_st[k] == 1 && tk) begin
                    if (m_by[k] <= 33) n_st[k] = 0;
                    else n_by[k] = m_by[k] - 2;
                end else if (m_st[k] == 2 && fs) n_st[k] = 0;
                else if (shot && k == fk) begin
                    n_st[k] = 1;
                    n_bx[k] = (int'(player_x) + 7) % 1024;
                    n_by[k] = (int'(player_y) + 1024 - 6) % 1024;
                end
            end
            n_cd = flush ? 0 : shot ? COOL : (m_cd > 0 && !pause) ? m_cd - 1 : m_cd;
            n_mc = pause ? m_mc : (m_mc + 1) % SPEED;
            @(posedge clk);
            for (int k = 0; k < NB; k++) begin m_st[k] = n_st[k]; m_bx[k] = n_bx[k]; m_by[k] = n_by[k]; end
            m_cd = n_cd; m_mc = n_mc; m_fq = n_fq; m_orgq = origin; m_sp = (hk >= 0);
            #1;
        end
    endtask

    task automatic flush_pool();
        game_over_on = 1; step(); game_over_on = 0;
    endtask

    task automatic fire_once();
        fire = 1; step(); fire = 0;
    endtask

    task automatic find_top(input int col, input int lo, input int hi, output int top);
        top = -1;
        x = 10'(col);
        for (int yy = lo; yy <= hi; yy++) begin
            y = 10'(yy);
            #1;
            if (b_on) begin top = yy; break; end
        end
    endtask

    task automatic test_reset();
        m_reset();
        step(); step();
        total++; if (b_on !== 1'b0) begin bad++; $display("FAIL reset_b_on got %0b want 0", b_on); end
        total++; if (hit_w_enemy !== 1'b0) begin bad++; $display("FAIL reset_hit got %0b want 0", hit_w_enemy); end
        total++; if (rgb !== 8'h00) begin bad++; $display("FAIL reset_rgb got %h want 00", rgb); end
        total++; if (score_pulse !== 1'b0) begin bad++; $display("FAIL reset_score got %0b want 0", score_pulse); end
        total++; if (active_count !== 4'd0) begin bad++; $display("FAIL reset_active got %0d want 0", active_count); end
        rst_n = 1;
    endtask

    task automatic test_fire();
        player_x = 300; player_y = 400;
        fire_once();
        total++; if (active_count !== 4'd1) begin bad++; $display("FAIL fire_active got %0d want 1", active_count); end
        x = 307; y = 394; #1;
        total++; if (b_on !== 1'b1) begin bad++; $display("FAIL fire_on_307_394 got %0b want 1", b_on); end
        total++; if (rgb !== 8'hFC) begin bad++; $display("FAIL fire_rgb got %h want fc", rgb); end
        x = 308; y = 399; #1;
        total++; if (b_on !== 1'b1) begin bad++; $display("FAIL fire_on_308_399 got %0b want 1", b_on); end
        x = 309; y = 394; #1;
        total++; if (b_on !== 1'b0) begin bad++; $display("FAIL fire_off_309_394 got %0b want 0", b_on); end
        x = 307; y = 400; #1;
        total++; if (b_on !== 1'b0) begin bad++; $display("FAIL fire_off_307_400 got %0b want 0", b_on); end
    endtask

    task automatic test_move();
        int tops[$];
        int t, last, pulses;
        int want[6] = '{40, 38, 36, 34, 32, -1};
        flush_pool();
        player_x = 100; player_y = 46;
        fire_once();
        last = -2; pulses = 0;
        for (int i = 0; i < 60; i++) begin
            find_top(107, 20, 50, t);
            if (t != last) begin tops.push_back(t); last = t; end
            if (t < 0) break;
            step();
            if (score_pulse) pulses++;
        end
        total++; if (tops.size() != 6) begin bad++; $display("FAIL move_steps got %0d want 6", tops.size()); end
        for (int i = 0; i < 6 && i < tops.size(); i++) begin
            total++; if (tops[i] != want[i]) begin bad++; $display("FAIL move_top[%0d] got %0d want %0d", i, tops[i], want[i]); end
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL move_score got %0d pulses want 0", pulses); end
        total++; if (active_count !== 4'd0) begin bad++; $display("FAIL move_exit_active got %0d want 0", active_count); end
    endtask

    task automatic test_hit();
        flush_pool();
        player_x = 200; player_y = 300;
        fire_once();
        x = 207; y = 297; e_w_on = 1; #1;
        total++; if (hit_w_enemy !== 1'b1) begin bad++; $display("FAIL hit_overlap got %0b want 1", hit_w_enemy); end
        step();
        total++; if (score_pulse !== 1'b1) begin bad++; $display("FAIL hit_pulse got %0b want 1", score_pulse); end
        step();
        total++; if (score_pulse !== 1'b0) begin bad++; $display("FAIL hit_pulse_once got %0b want 0", score_pulse); end
        total++; if (hit_w_enemy !== 1'b1) begin bad++; $display("FAIL hit_still_drawn got %0b want 1", hit_w_enemy); end
        e_w_on = 0;
        repeat (10) step();
        y = 294; #1;
        total++; if (b_on !== 1'b1) begin bad++; $display("FAIL hit_parked_top got %0b want 1", b_on); end
        y = 293; #1;
        total++; if (b_on !== 1'b0) begin bad++; $display("FAIL hit_parked_above got %0b want 0", b_on); end
        total++; if (active_count !== 4'd1) begin bad++; $display("FAIL hit_active got %0d want 1", active_count); end
        x = 0; y = 0;
        step();
        total++; if (active_count !== 4'd0) begin bad++; $display("FAIL hit_frame_free got %0d want 0", active_count); end
    endtask

    task automatic test_cooldown();
        int exp_a[5] = '{1, 1, 1, 1, 2};
        flush_pool();
        player_x = 300; player_y = 400; x = 5; y = 5;
        for (int e = 0; e < 5; e++) begin
            fire_once();
            total++; if (active_count !== 4'(exp_a[e])) begin bad++; $display("FAIL cool_edge%0d got %0d want %0d", e, active_count, exp_a[e]); end
            step(); step();
        end
        repeat (12) step(); fire_once();
        total++; if (active_count !== 4'd3) begin bad++; $display("FAIL cool_third got %0d want 3", active_count); end
        repeat (12) step(); fire_once();
        total++; if (active_count !== 4'd4) begin bad++; $display("FAIL cool_fourth got %0d want 4", active_count); end
        repeat (12) step(); fire_once();
        total++; if (active_count !== 4'd4) begin bad++; $display("FAIL cool_full_ignored got %0d want 4", active_count); end
        x = 10'(m_bx[0]); y = 10'(m_by[0]); e_w_on = 1;
        step();
        e_w_on = 0;
        total++; if (score_pulse !== 1'b1) begin bad++; $display("FAIL cool_hit_pulse got %0b want 1", score_pulse); end
        x = 0; y = 0;
        step();
        total++; if (active_count !== 4'd3) begin bad++; $display("FAIL cool_freed got %0d want 3", active_count); end
        fire_once();
        total++; if (active_count !== 4'd4) begin bad++; $display("FAIL cool_not_loaded got %0d want 4", active_count); end
    endtask

    task automatic test_pause();
        int t0, t1, eb, eh, es;
        flush_pool();
        player_x = 50; player_y = 200;
        fire_once();
        repeat (12) step();
        find_top(57, 150, 200, t0);
        pause = 1;
        eb = 0; eh = 0; es = 0;
        for (int i = 0; i < 400; i++) begin
            fire = i[0]; x = 57; y = 10'(t0 + 2); e_w_on = 1; #1;
            if (hit_w_enemy !== 1'b0) eh++;
            if (b_on !== 1'b1) eb++;
            step();
            if (score_pulse !== 1'b0) es++;
        end
        total++; if (eh != 0) begin bad++; $display("FAIL pause_hit_masked got %0d cycles high want 0", eh); end
        total++; if (eb != 0) begin bad++; $display("FAIL pause_drawn got %0d cycles low want 0", eb); end
        total++; if (es != 0) begin bad++; $display("FAIL pause_score got %0d pulses want 0", es); end
        fire = 0; e_w_on = 0;
        find_top(57, 150, 200, t1);
        total++; if (t1 != t0) begin bad++; $display("FAIL pause_frozen got %0d want %0d", t1, t0); end
        total++; if (active_count !== 4'd1) begin bad++; $display("FAIL pause_fire_ignored got %0d want 1", active_count); end
        pause = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            find_top(57, 150, 200, t1);
            if (t1 != t0) break;
        end
        total++; if (t1 != t0 - 2) begin bad++; $display("FAIL pause_resume got %0d want %0d", t1, t0 - 2); end
    endtask

    task automatic test_flush_reset();
        flush_pool();
        player_x = 400; player_y = 400; x = 5; y = 5;
        fire_once(); repeat (12) step();
        fire_once(); repeat (12) step();
        fire_once();
        total++; if (active_count !== 4'd3) begin bad++; $display("FAIL flush_setup got %0d want 3", active_count); end
        game_over_on = 1; step(); game_over_on = 0;
        total++; if (active_count !== 4'd0) begin bad++; $display("FAIL flush_active got %0d want 0", active_count); end
        fire_once();
        total++; if (active_count !== 4'd1) begin bad++; $display("FAIL flush_cd_cleared got %0d want 1", active_count); end
        x = 10'(m_bx[0]); y = 10'(m_by[0]); #1;
        total++; if (b_on !== 1'b1) begin bad++; $display("FAIL rst_pre_on got %0b want 1", b_on); end
        #40 rst_n = 0; #1;
        m_reset();
        total++; if (b_on !== 1'b0) begin bad++; $display("FAIL rst_async_b_on got %0b want 0", b_on); end
        total++; if (hit_w_enemy !== 1'b0) begin bad++; $display("FAIL rst_async_hit got %0b want 0", hit_w_enemy); end
        total++; if (rgb !== 8'h00) begin bad++; $display("FAIL rst_async_rgb got %h want 00", rgb); end
        total++; if (active_count !== 4'd0) begin bad++; $display("FAIL rst_async_active got %0d want 0", active_count); end
        step(); rst_n = 1; step();
        total++; if (active_count !== 4'd0) begin bad++; $display("FAIL rst_no_resume got %0d want 0", active_count); end
    endtask

    task automatic test_random();
        int live[$];
        int sel, k;
        bit eb;
        for (int i = 0; i < 3000; i++) begin
            pause         = ($urandom_range(0, 99) < 6);
            game_over_on  = ($urandom_range(0, 299) == 0);
            game_start_on = ($urandom_range(0, 299) == 0);
            fire          = ($urandom_range(0, 2) == 0);
            e_w_on        = $urandom_range(0, 1);
            player_x      = 10'($urandom_range(0, 600));
            player_y      = 10'($urandom_range(20, 470));
            live.delete();
            for (int j = 0; j < NB; j++) if (m_st[j] != 0) live.push_back(j);
            sel = $urandom_range(0, 9);
            if (sel < 5 && live.size() > 0) begin
                k = live[$urandom_range(0, live.size() - 1)];
                x = 10'(m_bx[k] + $urandom_range(0, 2));
                y = 10'(m_by[k] + $urandom_range(0, 6));
            end else if (sel == 5) begin
                x = 0; y = 0;
            end else begin
                x = 10'($urandom_range(0, 639));
                y = 10'($urandom_range(0, 479));
            end
            #1;
            eb = m_bon();
            total++; if (b_on !== eb) begin bad++; $display("FAIL rand_b_on cyc %0d got %0b want %0b", i, b_on, eb); end
            total++; if (hit_w_enemy !== (eb & ~pause)) begin bad++; $display("FAIL rand_hit cyc %0d got %0b want %0b", i, hit_w_enemy, eb & ~pause); end
            total++; if (rgb !== (eb ? 8'hFC : 8'h00)) begin bad++; $display("FAIL rand_rgb cyc %0d got %h", i, rgb); end
            step();
            total++; if (score_pulse !== m_sp) begin bad++; $display("FAIL rand_score cyc %0d got %0b want %0b", i, score_pulse, m_sp); end
            total++; if (active_count !== 4'(m_active())) begin bad++; $display("FAIL rand_active cyc %0d got %0d want %0d", i, active_count, m_active()); end
        end
        pause = 0; game_over_on = 0; game_start_on = 0; fire = 0; e_w_on = 0;
    endtask

    initial begin
        test_reset();
        test_fire();
        test_move();
        test_hit();
        test_cooldown();
        test_pause();
        test_flush_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
